tri_lifo: RTL and testbench

TRI_LIFO -- requirements
Module: tri_lifo

---
 rtl/tri_lifo.sv | 106 ++++++++++
 tb/tb_tri_lifo.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tri_lifo.sv
// tri_lifo: LIFO stack of Triangle3D entries with registered pop output and optional
// sticky overflow/underflow flags (enabled by defining TRI_LIFO_ERR_EN).
package tri_lifo_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D a;
        Vertex3D b;
        Vertex3D c;
    } Triangle3D;
endpackage

module tri_lifo
    import tri_lifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = $bits(Triangle3D),
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [WIDTH-1:0]         tri_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         tri_out,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tri_lifo: DEPTH must be a power of two in 2..256");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] top_entry;

    assign top_idx     = AW'(cnt - CW'(1));
    assign wr_idx      = AW'(cnt);
    assign top_entry   = mem[top_idx];
    assign count       = cnt;
    assign empty       = cnt == '0;
    assign full        = int'(cnt) == DEPTH;
    assign almost_full = int'(cnt) >= AF_LEVEL;
    assign top         = empty ? '0 : top_entry;

    // Storage is deliberately unreset; only the count decides what is valid.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push && !pop && !full)
                mem[wr_idx] <= tri_in;
            else if (push && pop && !empty)
                mem[top_idx] <= tri_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt     <= '0;
            tri_out <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (push && pop) begin
            tri_out <= empty ? tri_in : top_entry;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            tri_out <= top_entry;
            cnt     <= cnt - CW'(1);
        end
    end

`ifdef TRI_LIFO_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !pop && full)
                overflow <= 1'b1;
            if (pop && !push && empty)
                underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_tri_lifo.sv
// tb_tri_lifo: directed self-checking bench for tri_lifo with a stack model and
// a scoreboard of expected tri_out values.
module tb_tri_lifo;
    import tri_lifo_pkg::*;
    localparam int W = $bits(Triangle3D);
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [W-1:0] tri_in = '0;
    logic         push = 1'b0, pop = 1'b0, clear = 1'b0;
    logic [W-1:0] tri_out, top;
    logic [3:0]   count;
    logic         empty, full, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;
`ifdef TRI_LIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic [W-1:0] stk[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_out = '0;
    logic         ov_m = 1'b0, un_m = 1'b0;

    tri_lifo dut (
        .clk(clk), .n_rst(n_rst), .tri_in(tri_in), .push(push), .pop(pop), .clear(clear),
        .tri_out(tri_out), .top(top), .count(count), .empty(empty), .full(full),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] v(input int i);
        return {16'(11*i), 16'(22*i), 16'(33*i), 16'(i), 16'(2*i), 16'(4*i),
                16'(8*i), 16'(6*i), 16'(7*i)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        if (sb.size() > 0) exp_out = sb.pop_front();
        chk({tag, ".tri_out"}, tri_out, exp_out);
        chk({tag, ".count"}, count, stk.size());
        chk({tag, ".empty"}, empty, stk.size() == 0);
        chk({tag, ".full"}, full, stk.size() == D);
        chk({tag, ".almost_full"}, almost_full, stk.size() >= D - 1);
        chk({tag, ".top"}, top, stk.size() > 0 ? stk[$] : '0);
        chk({tag, ".overflow"}, overflow, ov_m & ERR_EN);
        chk({tag, ".underflow"}, underflow, un_m & ERR_EN);
    endtask

    task automatic model_reset();
        stk.delete();
        sb.delete();
        exp_out = '0;
        ov_m = 1'b0;
        un_m = 1'b0;
    endtask

    task automatic step(input string tag, input logic p, input logic q, input logic c,
                        input logic [W-1:0] d);
        push = p; pop = q; clear = c; tri_in = d;
        if (c) begin
            stk.delete();
            ov_m = 1'b0;
            un_m = 1'b0;
        end else if (p && q) begin
            if (stk.size() == 0) sb.push_back(d);
            else begin
                sb.push_back(stk[$]);
                stk[$] = d;
            end
        end else if (p) begin
            if (stk.size() < D) stk.push_back(d);
            else ov_m = 1'b1;
        end else if (q) begin
            if (stk.size() > 0) sb.push_back(stk.pop_back());
            else un_m = 1'b1;
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #2;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) step("push8", 1'b1, 1'b0, 1'b0, v(i));
        for (int i = 0; i < 8; i++) step("pop8", 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 1'b0, v(i));
        step("push_full", 1'b1, 1'b0, 1'b0, v(9));
        step("pushpop_full", 1'b1, 1'b1, 1'b0, v(9));
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);
        step("bypass", 1'b1, 1'b1, 1'b0, v(3));
        step("pop_empty", 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step("push5", 1'b1, 1'b0, 1'b0, v(i + 10));
        step("clear_push", 1'b1, 1'b0, 1'b1, v(20));
        step("pop_after_clear", 1'b0, 1'b1, 1'b0, '0);
        step("push_a", 1'b1, 1'b0, 1'b0, v(4));
        step("pop_a", 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step("burst", 1'b1, 1'b0, 1'b0, v(i + 1));
        push = 1'b1;
        tri_in = v(6);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        push = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        step("pop_after_reset", 1'b0, 1'b1, 1'b0, '0);
        step("push_b", 1'b1, 1'b0, 1'b0, v(5));
        step("pop_b", 1'b0, 1'b1, 1'b0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
